pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard types:
- load-use hazards, by inserting an ID/EX bubble;
- taken branches, by flushing IF/ID;
- multi-cycle data-memory accesses, by freezing the whole pipeline through a start/ack handshake, with a timeout watchdog.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum WAIT cycles before the error trap; legal range 1..65535.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clock_i  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- IDEX_memread_i  in  1  instruction in EX is a load.
- IDEX_rd_i  in  5  destination register of the instruction in EX.
- IFID_rs1_i  in  5  rs1 of the instruction in ID.
- IFID_rs2_i  in  5  rs2 of the instruction in ID.
- branch_taken_i  in  1  ID-stage branch/jump resolved as taken.
- mem_req_i  in  1  instruction in MEM is a load or store.
- mem_ack_i  in  1  data memory has completed the access.
- pc_enable_o  out  1  PC update enable.
- IFID_enable_o  out  1  IF/ID register enable.
- IFID_flush_o  out  1  IF/ID clear.
- IDEX_enable_o  out  1  ID/EX register enable.
- IDEX_flush_o  out  1  ID/EX clear (bubble insertion).
- EXMEM_enable_o  out  1  EX/MEM register enable.
- MEMWB_enable_o  out  1  MEM/WB register enable.
- mem_start_o  out  1  one-cycle pulse that launches a data-memory access.
- error_o  out  1  sticky memory-timeout flag.
- stall_cycles_o  out  STALL_CNT_W  saturating count of cycles with pc_enable_o=0.

## Operation
State machine with three states: RUN, WAIT, ERR. All outputs are combinational from the state and the inputs.

Load-use hazard:
- load_use = IDEX_memread_i & (IDEX_rd_i != 0) & (IDEX_rd_i == IFID_rs1_i | IDEX_rd_i == IFID_rs2_i).

RUN, mem_req_i=1:
- mem_start_o=1.
- All enables=0; all flushes=0.
- Next state WAIT; timer cleared to 0.

RUN, mem_req_i=0, load_use=1:
- pc_enable_o=0 and IFID_enable_o=0.
- IDEX_flush_o=1.
- EXMEM_enable_o=1 and MEMWB_enable_o=1.
- branch_taken_i is ignored (its operands are not yet valid).

RUN, mem_req_i=0, load_use=0:
- All enables=1.
- IFID_flush_o=branch_taken_i.
- IDEX_flush_o=0.

WAIT, mem_ack_i=1:
- All enables=1; flushes follow the RUN no-request rules, including load_use and branch_taken_i.
- Next state RUN.

WAIT, mem_ack_i=0:
- All enables=0; timer increments.
- If timer == MEM_TIMEOUT-1, next state is ERR.

ERR:
- All enables=0; mem_start_o=0; error_o=1.
- Exited only by reset.

Other rules:
- Priority: memory freeze > load-use > branch flush. No flush is asserted while frozen.
- mem_ack_i is ignored outside WAIT.
- mem_start_o is never asserted in consecutive cycles.
- stall_cycles_o increments in every non-reset cycle where pc_enable_o=0 and saturates at all-ones.

## Timing
- While rst_i=0 (sampled at the clock edge):
  - state goes to RUN; timer=0; stall_cycles_o=0; error_o=0.
  - While rst_i is low, combinational outputs are forced: all enables=0, IFID_flush_o=1, IDEX_flush_o=1, mem_start_o=0.
- Reset asserted during WAIT abandons the access. No new start is issued until a fresh mem_req_i is seen in RUN.
- Minimum memory-access cost: the start cycle plus ≥1 WAIT cycle. With ack in the first WAIT cycle, the pipeline is frozen for exactly 1 cycle and advances in the ack cycle.
- Load-use costs exactly one bubble cycle. The next cycle re-evaluates with the load now in MEM.
- A back-to-back memory instruction arriving in MEM right after an ack produces a new start pulse in the following RUN cycle.
- The timeout trips after exactly MEM_TIMEOUT consecutive WAIT cycles without ack. error_o rises the cycle after.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles_o counter is implemented as described.
- PIPE_CTRL_PERF_EN undefined: the counter is not built; stall_cycles_o is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then idle with all hazard inputs 0 → all enables=1, flushes=0, stall_cycles_o=0.
- IDEX_memread_i=1, IDEX_rd_i=5, IFID_rs2_i=5, branch_taken_i=1 → one cycle with pc/IFID enable=0, IDEX_flush_o=1, IFID_flush_o=0. Repeat with IDEX_rd_i=0 → no stall.
- mem_req_i=1, ack after 3 WAIT cycles → mem_start_o single pulse, then 4 frozen cycles, advance in the ack cycle, stall_cycles_o=4 (with PIPE_CTRL_PERF_EN).
- MEM_TIMEOUT=4, mem_req_i=1, never ack → ERR after 4 WAIT cycles, error_o=1 sticky, enables stay 0 until rst_i=0.
- Reset pulsed during WAIT, then ack → ack ignored, state RUN, no mem_start_o until mem_req_i is re-presented.
- Branch taken alone in RUN → IFID_flush_o=1 for one cycle, all enables=1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
// It resolves three hazards: load-use (ID/EX bubble), taken branch (IF/ID flush),
// and multi-cycle data-memory access (whole-pipeline freeze with a start/ack
// handshake and a timeout watchdog that traps into a sticky error state).
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating stall-cycle
// counter. Without it, stall_cycles_o is tied to zero.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock_i,
    input  logic                   rst_i,
    input  logic                   IDEX_memread_i,
    input  logic [4:0]             IDEX_rd_i,
    input  logic [4:0]             IFID_rs1_i,
    input  logic [4:0]             IFID_rs2_i,
    input  logic                   branch_taken_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ack_i,
    output logic                   pc_enable_o,
    output logic                   IFID_enable_o,
    output logic                   IFID_flush_o,
    output logic                   IDEX_enable_o,
    output logic                   IDEX_flush_o,
    output logic                   EXMEM_enable_o,
    output logic                   MEMWB_enable_o,
    output logic                   mem_start_o,
    output logic                   error_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Timer value of the last WAIT cycle that may still see an ack.
    localparam logic [15:0] TIMER_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_r;
    logic [15:0] timer_r;
    logic        load_use_s;
    logic        pc_enable_s;
    logic        ifid_enable_s;
    logic        ifid_flush_s;
    logic        idex_enable_s;
    logic        idex_flush_s;
    logic        exmem_enable_s;
    logic        memwb_enable_s;
    logic        mem_start_s;
    logic        error_s;

    // Detect a load in EX whose destination feeds the instruction in ID.
    always_comb begin
        load_use_s = IDEX_memread_i & (IDEX_rd_i != 5'd0) &
                     ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i));
    end

    // Decode pipeline controls from state and hazard inputs (freeze > load-use > branch).
    always_comb begin
        pc_enable_s    = 1'b0;
        ifid_enable_s  = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_enable_s  = 1'b0;
        idex_flush_s   = 1'b0;
        exmem_enable_s = 1'b0;
        memwb_enable_s = 1'b0;
        mem_start_s    = 1'b0;
        error_s        = 1'b0;
        if (!rst_i) begin
            // Hold everything and clear the front-end registers while in reset.
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_req_i) begin
                        // Launch the access; the whole pipeline freezes.
                        mem_start_s = 1'b1;
                    end else if (load_use_s) begin
                        // Hold PC and IF/ID, push a bubble into ID/EX; branch ignored.
                        idex_enable_s  = 1'b1;
                        idex_flush_s   = 1'b1;
                        exmem_enable_s = 1'b1;
                        memwb_enable_s = 1'b1;
                    end else begin
                        pc_enable_s    = 1'b1;
                        ifid_enable_s  = 1'b1;
                        idex_enable_s  = 1'b1;
                        exmem_enable_s = 1'b1;
                        memwb_enable_s = 1'b1;
                        ifid_flush_s   = branch_taken_i;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        // Access done: the pipeline advances in this same cycle.
                        pc_enable_s    = 1'b1;
                        ifid_enable_s  = 1'b1;
                        idex_enable_s  = 1'b1;
                        exmem_enable_s = 1'b1;
                        memwb_enable_s = 1'b1;
                        idex_flush_s   = load_use_s;
                        ifid_flush_s   = branch_taken_i & ~load_use_s;
                    end else begin
                        // Still frozen: every control keeps its inactive default.
                        mem_start_s = 1'b0;
                    end
                end
                ST_ERR: begin
                    error_s = 1'b1;
                end
                default: begin
                    error_s = 1'b0;
                end
            endcase
        end
    end

    // Sequence RUN/WAIT/ERR and run the memory-timeout watchdog.
    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            state_r <= ST_RUN;
            timer_r <= 16'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_req_i) begin
                        state_r <= ST_WAIT;
                        timer_r <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        state_r <= ST_RUN;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                        if (timer_r == TIMER_LAST) begin
                            state_r <= ST_ERR;
                        end
                    end
                end
                ST_ERR: begin
                    state_r <= ST_ERR;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Count cycles in which the PC is held, saturating at all-ones.
    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (!pc_enable_s && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + STALL_ONE;
        end
    end

    assign stall_cycles_o = stall_cnt_r;
`else
    assign stall_cycles_o = {STALL_CNT_W{1'b0}};
`endif

    assign pc_enable_o    = pc_enable_s;
    assign IFID_enable_o  = ifid_enable_s;
    assign IFID_flush_o   = ifid_flush_s;
    assign IDEX_enable_o  = idex_enable_s;
    assign IDEX_flush_o   = idex_flush_s;
    assign EXMEM_enable_o = exmem_enable_s;
    assign MEMWB_enable_o = memwb_enable_s;
    assign mem_start_o    = mem_start_s;
    assign error_o        = error_s;

endmodule
